// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch stage.
//   imem_req    : fetch request valid (master -> slave)
//   imem_addr   : fetch address, 32 bits (master -> slave)
//   imem_ready  : slave accepts the request this cycle
//   imem_rvalid : response data valid
//   imem_rdata  : instruction word, 32 bits
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction at a time
// over the imem interface, presents it to the decoder for a DECODE and an
// EXEC cycle, then redirects or advances the PC using branch/jump from the
// decoder.
//   clk, rst_n     : clock, synchronous active-low reset
//   imem           : instruction-memory master port (req/addr/ready/rvalid/rdata)
//   branch_i/jump_i/zero_i/imm_ext_i : redirect controls, valid in EXEC
//   hold_i         : downstream stall, freezes EXEC
//   instr_o/op_o   : held instruction and its opcode field
//   pc_o/pc_plus4_o: PC of the held instruction and its successor
//   instr_valid_o  : instr_o is live (DECODE or EXEC)
//   retire_o       : one-cycle completion pulse
//   instret_o      : retired-instruction counter
//   fetch_fault_o  : sticky misaligned-target flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               branch_i,
  input  logic               jump_i,
  input  logic               zero_i,
  input  logic [31:0]        imm_ext_i,
  input  logic               hold_i,
  output logic [31:0]        instr_o,
  output logic [6:0]         op_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic               instr_valid_o,
  output logic               retire_o,
  output logic [31:0]        instret_o,
  output logic               fetch_fault_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            retire_q, retire_d;
  logic            fault_q, fault_d;
  logic            pc_src;
  logic [XLEN-1:0] next_pc;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
      retire_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      retire_q  <= retire_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state and redirect logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    retire_d  = 1'b0;
    fault_d   = fault_q;
    pc_src    = jump_i | (branch_i & zero_i);
    next_pc   = pc_src ? (pc_q + imm_ext_i) : (pc_q + XLEN'(4));

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      // imem_req is high throughout FETCH, so ready alone completes the handshake
      S_FETCH:  if (imem.imem_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!hold_i) begin
          instr_d = NOP_INSTR;
          if (next_pc[1:0] != 2'b00) begin
            // Misaligned target: keep the faulting PC for inspection
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d      = next_pc;
            retire_d  = 1'b1;
            instret_d = instret_q + XLEN'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register and registered values
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid_o  = (state_q == S_DECODE) || (state_q == S_EXEC);
  assign instr_o        = instr_q;
  assign op_o           = instr_q[OPW-1:0];
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_q + XLEN'(4);
  assign retire_o       = retire_q;
  assign instret_o      = instret_q;
  assign fetch_fault_o  = fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of `main_decoder`. It holds the PC, fetches instructions over a valid/ready instruction-memory interface, and presents `instr` and `op` to the decoder. Because the decoder registers its controls on `posedge clk`, the unit holds each instruction for two cycles. At the end of the second cycle it uses the decoder's `branch`/`jump` to compute the next PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: value of `instr` when no instruction is held (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: instruction word.
- `branch`, `jump`, `zero` in 1 each: from `main_decoder` and the ALU.
- `imm_ext` in 32: sign-extended immediate.
- `hold` in 1: downstream stall request.
- `instr` out 32: held instruction.
- `op` out 7: `instr[6:0]`, drives `main_decoder.op`.
- `pc` out 32: PC of the held instruction.
- `pc_plus4` out 32: `pc + 4`, feeds `result_src = 2'b10`.
- `instr_valid` out 1: `instr` is live (DECODE or EXEC).
- `retire` out 1: one-cycle pulse when the instruction completes.
- `instret` out 32: retired-instruction counter.
- `fetch_fault` out 1: sticky misaligned-target flag.

## Operation
- FSM states are IDLE, FETCH, WAIT, DECODE, EXEC, HALT.
- **IDLE**: entered on reset; moves to FETCH on the next cycle.
- **FETCH**:
  - `imem_req = 1` and `imem_addr = pc`, both held stable until the handshake.
  - `imem_req && imem_ready` at a rising edge: go to WAIT.
- **WAIT**:
  - `imem_req = 0`.
  - `imem_rvalid` at a rising edge: `instr <= imem_rdata`, go to DECODE.
  - `imem_rvalid` is ignored in every state other than WAIT.
- **DECODE**: `instr` is presented for exactly one cycle; `main_decoder` registers its controls at the end of this cycle. Go to EXEC.
- **EXEC**: `branch`, `jump`, `zero` and `imm_ext` are valid.
  - If `hold = 1`: remain in EXEC with all state frozen.
  - Otherwise, at the rising edge:
    - `pc_src = jump | (branch & zero)`.
    - `next_pc = pc_src ? pc + imm_ext : pc + 4`, using modulo-2^32 addition.
    - Misaligned target (`next_pc[1:0] != 0`): set `fetch_fault <= 1`, go to HALT, leave `pc` unchanged, no retire.
    - Otherwise: `pc <= next_pc`, pulse `retire`, `instret <= instret + 1`, set `instr <= NOP_INSTR`, go to FETCH.
- **HALT**:
  - Terminal state; only reset exits.
  - `imem_req = 0`, `instr_valid = 0`, `instr = NOP_INSTR`.
- `instret` wraps from 32'hFFFF_FFFF to 0 with no flag.
- `pc` wraps modulo 2^32.
- **Reset**: a low `rst_n` at any rising edge, including mid-transaction in WAIT, forces the reset values.
  - Any outstanding response is discarded.
  - A late `imem_rvalid` arriving in IDLE or FETCH is ignored.
- **Reset values**:
  - state = IDLE, `pc` = `RESET_PC`, `instr` = `NOP_INSTR`.
  - `imem_req` = 0, `instr_valid` = 0, `retire` = 0, `instret` = 0, `fetch_fault` = 0.

## Timing
- All outputs except `imem_req`, `imem_addr`, `op`, `pc_plus4` and `instr_valid` are registered.
  - `imem_req` and `instr_valid` are decoded from the state register.
  - `imem_addr`, `op` and `pc_plus4` are decoded from registered values.
- **Minimum instruction period** is 4 cycles: FETCH, WAIT, DECODE, EXEC.
  - This requires `imem_ready = 1` in FETCH and `imem_rvalid = 1` in the first WAIT cycle.
  - Each extra ready-low, rvalid-low or `hold` cycle adds one cycle.
- **First request**: `imem_req` first rises in cycle 2 after `rst_n` deasserts (cycle 1 is IDLE).
- **`retire` pulse**: asserted for exactly the one cycle after the EXEC exit edge; `instret` shows the new value in that same cycle.
- **`hold` vs. redirect**: `hold` has priority. A held EXEC that later releases uses the inputs present on the release cycle.

## Test plan
- **Reset and sequential fetch**: `RESET_PC=0`, memory always ready, rvalid one cycle after handshake, program of four `addi` at 0, 4, 8, 12.
  - `imem_req` high in cycle 2.
  - `imem_addr` sequence 0, 4, 8, 12, each 4 cycles apart.
  - `instret = 4` after the 4th retire.
- **Taken branch**: at `pc = 8`, `branch = 1`, `zero = 1`, `imm_ext = 32'hFFFF_FFF8`.
  - Next fetch address is 0.
  - With `zero = 0`, the next fetch address is 12.
- **Jal**: at `pc = 4`, `jump = 1`, `imm_ext = 16`.
  - `pc_plus4 = 8` during EXEC.
  - Next `imem_addr = 20`.
- **Memory backpressure**: `imem_ready` low 3 cycles, then `imem_rvalid` delayed 2 cycles.
  - `imem_addr` is stable throughout.
  - Instruction period is 9 cycles.
  - A spurious `imem_rvalid` during FETCH does not change `instr`.
- **Hold and wrap**: `hold` high 5 cycles in EXEC.
  - No `retire`; `pc` is frozen.
  - Separately, preload `instret = 32'hFFFF_FFFF` via a force: the next retire gives 0.
- **Fault and reset mid-operation**: `jump = 1`, `imm_ext = 2`.
  - `fetch_fault = 1`, state HALT, `imem_req = 0`, `pc` unchanged.
  - Assert `rst_n = 0` in the WAIT of a later run: `pc` returns to `RESET_PC`, and a response arriving after reset is discarded.
